mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the processor's single unified 16-bit memory port between two requesters.
- Instruction fetch (IF, driven by the IRWrite phase of the multicycle controller) and data access (DM, driven by MemRead/MemWrite).
- Sequences each transaction through a small FSM with round-robin fairness and fixed memory read latency.
- Sits between the controller/datapath and the memory array.

Parameters:
AW, 16, address width
DW, 16, data width
MEM_LAT, 2, cycles from mem_en (read) until mem_rdata is valid; legal range 1..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  AW  fetch address; stable while if_req
if_gnt  out  1  one-cycle pulse: fetch accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched instruction word
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = write, 0 = read; stable while dm_req
dm_addr  in  AW  data address
dm_wdata  in  DW  write data
dm_gnt  out  1  one-cycle pulse: data request accepted
dm_rvalid  out  1  one-cycle pulse: dm_rdata valid (reads only)
dm_rdata  out  DW  read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  1 whenever state != IDLE

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. All outputs are registered.
- Reset values: state=IDLE; all gnt/rvalid/mem_en/mem_we/busy=0; addr/data outputs=0; last_owner=DM, so IF wins the first tie.
- Arbitration point is IDLE or RESP. Request sampled at edge:
  - only one requester → that requester wins;
  - both → the one not equal to last_owner wins.
  - Winner's addr/we/wdata latched; last_owner updated; next state ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we=winner write; mem_addr/mem_wdata = latched values;
  - winner's gnt=1 in this same cycle.
  - IF is always a read.
  - Write → next IDLE; no rvalid is ever produced for a write.
  - Read → next WAIT, with counter loaded to MEM_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, mem_rdata is captured into the owner's rdata register at that edge; next state RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP (1 cycle): owner's rvalid=1, rdata holds the captured word. Arbitration runs in this cycle for back-to-back issue.
- Read timing: request seen at edge 0 → ACCESS cycle 1 → rdata valid in cycle 1+MEM_LAT → rvalid in cycle 2+MEM_LAT.
- Throughput:
  - back-to-back reads: one every MEM_LAT+2 cycles;
  - writes: ACCESS followed by one IDLE cycle.
- rdata registers keep their last value until overwritten. Each requester's rdata is independent.
- Requests arriving in ACCESS or WAIT are not sampled; requesters hold them.
- A request deasserted before its gnt is dropped with no side effect.
- rst in any state: IDLE at the next edge; in-flight read data discarded, no rvalid issued.
- Never more than one gnt per cycle; never an rvalid for a non-owner.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3;
  - owner encoding OWN_IF=1'b0, OWN_DM=1'b1.
- One sub-module: rr_arb2, a 2-input round-robin picker (req vector plus last_owner → winner, valid); purely combinational.
- The FSM, latency counter and capture registers stay in mem_port_arbiter.

Test Plan (MEM_LAT=2):
1. Reset held 2 cycles with if_req=dm_req=1 → no gnt, mem_en=0, busy=0 throughout reset. Release → first grant goes to IF.
2. if_req, if_addr=16'h0040, mem returns 16'hA5A5 → if_gnt and mem_en in cycle 1, mem_addr=16'h0040, mem_we=0, if_rvalid in cycle 4 with if_rdata=16'hA5A5.
3. dm_req, dm_we=1, dm_addr=16'h0100, dm_wdata=16'h1234 → cycle 1: dm_gnt=1, mem_en=1, mem_we=1, mem_wdata=16'h1234. No dm_rvalid. busy=0 in cycle 2.
4. Both reads held continuously → grants alternate IF, DM, IF, DM on consecutive RESP arbitration, ACCESS every 4 cycles. Each rvalid is routed to the correct port with matching data.
5. rst asserted during WAIT of a DM read → next cycle IDLE, no dm_rvalid ever issued for it, mem_en=0.
6. Sweep MEM_LAT=1 and 7 → rvalid exactly MEM_LAT+1 cycles after gnt. Captured data equals mem_rdata present in the final WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
  typedef logic owner_t;
  localparam owner_t OWN_IF = 1'b0;
  localparam owner_t OWN_DM = 1'b1;
  localparam int CNT_W = 3;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; on a tie the requester that did not own the port last wins
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_last,
  output owner_t     o_winner,
  output logic       o_valid
);
  assign o_valid  = |i_req;
  assign o_winner = &i_req ? owner_t'(~i_last) : owner_t'(i_req[1]);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);
  state_t           r_state, w_next;
  owner_t           r_owner, w_win;
  logic             w_vld, w_arb, w_cap;
  logic [CNT_W-1:0] r_cnt;
  logic             r_if_gnt, r_if_rvalid, r_dm_gnt, r_dm_rvalid, r_mem_en, r_mem_we, r_busy;
  logic [DW-1:0]    r_if_rdata, r_dm_rdata, r_mem_wdata;
  logic [AW-1:0]    r_mem_addr;
  rr_arb2 u_arb (
    .i_req    ({dm_req, if_req}),
    .i_last   (r_owner),
    .o_winner (w_win),
    .o_valid  (w_vld)
  );
  always_comb begin
    w_arb  = (r_state == ST_IDLE || r_state == ST_RESP) && w_vld;
    w_cap  = r_state == ST_WAIT && r_cnt == '0;
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: w_next = w_arb ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:        w_next = r_mem_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:          w_next = w_cap ? ST_RESP : ST_WAIT;
      default:          w_next = ST_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_DM;
      r_cnt       <= '0;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= w_next != ST_IDLE;
      r_mem_en    <= w_arb;
      r_if_gnt    <= w_arb && w_win == OWN_IF;
      r_dm_gnt    <= w_arb && w_win == OWN_DM;
      r_mem_we    <= w_arb && w_win == OWN_DM && dm_we;
      r_if_rvalid <= w_cap && r_owner == OWN_IF;
      r_dm_rvalid <= w_cap && r_owner == OWN_DM;
      if (r_state == ST_ACCESS)
        r_cnt <= LAT_M1;
      else if (r_state == ST_WAIT)
        r_cnt <= r_cnt - 1'b1;
      if (w_arb) begin
        r_owner    <= w_win;
        r_mem_addr <= w_win == OWN_DM ? dm_addr : if_addr;
        if (w_win == OWN_DM)
          r_mem_wdata <= dm_wdata;
      end
      if (w_cap && r_owner == OWN_IF)
        r_if_rdata <= mem_rdata;
      if (w_cap && r_owner == OWN_DM)
        r_dm_rdata <= mem_rdata;
    end
  end
  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
endmodule
